scan_display_controller: RTL and testbench

// Time-multiplexing scheduler for a shared 7-segment bus driving NUM_DIGITS common-anode-select displays.

---
 rtl/scan_display_controller_pkg.sv | 33 +++
 rtl/scan_display_controller_if.sv | 35 +++
 rtl/scan_display_controller_hex_to_7seg.sv | 33 +++
 rtl/scan_display_controller.sv | 158 +++++++++++++++
 tb/tb_scan_display_controller.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_display_controller_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller.
// Holds the gfedcba segment patterns (active-high) for each hex value,
// the dark pattern, and the scan FSM state type.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Digit register value after reset: blank flag set, hex 0.
    localparam logic [4:0] DIGIT_BLANK = 5'h10;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

endpackage

// File: rtl/scan_display_controller_if.sv
// Host-side bus of the scan display controller.
// master: digit producer (drives enable and the digit write port, observes scan outputs)
// slave : scan_display_controller
//   enable      1 = scan, 0 = dark and parked
//   wr_en       digit register write strobe
//   wr_addr     digit index to write
//   wr_data     [4] blank flag, [3:0] hex value
//   segmentos   gfedcba, active-high
//   anodos      one-hot digit select, active-high
//   digit_idx   digit currently scheduled
//   frame_done  1-cycle pulse when the last digit's dwell ends
interface scan_display_if #(
    parameter int unsigned NUM_DIGITS = 2
);
    localparam int unsigned AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                  enable;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [4:0]            wr_data;
    logic [6:0]            segmentos;
    logic [NUM_DIGITS-1:0] anodos;
    logic [AW-1:0]         digit_idx;
    logic                  frame_done;

    modport master (
        output enable, wr_en, wr_addr, wr_data,
        input  segmentos, anodos, digit_idx, frame_done
    );

    modport slave (
        input  enable, wr_en, wr_addr, wr_data,
        output segmentos, anodos, digit_idx, frame_done
    );
endinterface

// File: rtl/scan_display_controller_hex_to_7seg.sv
// Combinational hex digit to gfedcba segment decoder.
//   hex_i  4-bit value
//   seg_o  active-high segment pattern
module hex_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (hex_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/scan_display_controller.sv
// Time-multiplexed scan controller for NUM_DIGITS 7-segment displays on a
// shared segment bus. Each digit gets one dwell of DWELL_CYCLES clocks: the
// first BLANK_CYCLES are dark (anti-ghosting), the rest drive the anode and
// the decoded digit value captured at the start of the drive phase.
//   clock_50mhz  system clock, posedge
//   reset        synchronous, active-high
//   bus          scan_display_if slave (enable, digit writes, scan outputs)
module scan_display_controller
    import display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 2,
    parameter int unsigned CLK_FREQ_HZ  = 50_000_000,
    parameter int unsigned DIGIT_HZ     = 2_000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic           clock_50mhz,
    input  logic           reset,
    scan_display_if.slave  bus
);

    localparam int unsigned DWELL_CYCLES = CLK_FREQ_HZ / DIGIT_HZ;
    localparam int unsigned AW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [AW-1:0] IDX_LAST   = AW'(NUM_DIGITS - 1);

    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DWELL_CYCLES) begin : g_bad_blank
        $error("BLANK_CYCLES must be >= 1 and < CLK_FREQ_HZ/DIGIT_HZ");
    end
    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("NUM_DIGITS must be in 2..8");
    end

    // ---------------- digit registers ----------------
    logic [4:0] digit_q [NUM_DIGITS];
    logic       wr_ok;

    assign wr_ok = bus.wr_en && ({1'b0, bus.wr_addr} < (AW+1)'(NUM_DIGITS));

    always_ff @(posedge clock_50mhz) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= DIGIT_BLANK;
            end
        end else if (wr_ok) begin
            digit_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    // ---------------- scan FSM ----------------
    scan_state_t           state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [4:0]            snap_q, snap_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_q, frame_d;
    logic                  capture;
    logic [6:0]            seg_dec;

    // Decodes the snapshot value as it is being captured, so segments and the
    // anode are registered on the same edge.
    hex_to_7seg u_dec (
        .hex_i (snap_d[3:0]),
        .seg_o (seg_dec)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        frame_d = 1'b0;
        capture = 1'b0;
        an_d    = '0;
        seg_d   = SEG_BLANK;

        if (!bus.enable) begin
            state_d = OFF;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) begin
                        state_d = DRIVE;
                        capture = 1'b1;
                    end
                end
                DRIVE: begin
                    if (cnt_q == DWELL_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = '0;
                            frame_d = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = OFF;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end

        // A write landing on the capture edge is forwarded into the snapshot.
        if (capture) begin
            snap_d = (wr_ok && bus.wr_addr == idx_q) ? bus.wr_data : digit_q[idx_q];
        end

        if (state_d == DRIVE) begin
            an_d = NUM_DIGITS'(1) << idx_d;
            if (!snap_d[4]) begin
                seg_d = seg_dec;
            end
        end
    end

    always_ff @(posedge clock_50mhz) begin
        if (reset) begin
            state_q <= OFF;
            cnt_q   <= '0;
            idx_q   <= '0;
            snap_q  <= DIGIT_BLANK;
            seg_q   <= SEG_BLANK;
            an_q    <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
            frame_q <= frame_d;
        end
    end

    assign bus.segmentos  = seg_q;
    assign bus.anodos     = an_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_scan_display_controller.sv
// Bench for scan_display_controller: DWELL=10, BLANK=2 (drive 8 cycles).
// Stimulus queues one expected record per drive window; monitors rebuild
// windows from the outputs and compare against the queue.
module tb_scan_display_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;

    scan_display_if #(.NUM_DIGITS(4)) bus_a ();
    scan_display_if #(.NUM_DIGITS(3)) bus_b ();

    scan_display_controller #(
        .NUM_DIGITS(4), .CLK_FREQ_HZ(1000), .DIGIT_HZ(100), .BLANK_CYCLES(2)
    ) dut_a (
        .clock_50mhz (clk),
        .reset       (rst_a),
        .bus         (bus_a)
    );

    scan_display_controller #(
        .NUM_DIGITS(3), .CLK_FREQ_HZ(1000), .DIGIT_HZ(100), .BLANK_CYCLES(2)
    ) dut_b (
        .clock_50mhz (clk),
        .reset       (rst_b),
        .bus         (bus_b)
    );

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] idx;
        int         len;
        int         gap;
        int         fr;
    } win_t;

    typedef struct {
        logic [2:0] an;
        logic [6:0] seg;
        logic [1:0] idx;
    } win_b_t;

    win_t   q_a [$];
    win_b_t q_b [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input bit ok, input string act, input string req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %s, expected %s", name, act, req);
        end
    endtask

    function automatic string wstr(input win_t w);
        return $sformatf("an=%b seg=%h idx=%0d len=%0d gap=%0d fr=%0d",
                         w.an, w.seg, w.idx, w.len, w.gap, w.fr);
    endfunction

    // ---------------- monitor A ----------------
    int   gap_a = 0, fr_a = 0, cyc = 0, last_fr = 0, win_no = 0;
    bit   pv = 1'b0, in_win = 1'b0, stable = 1'b1;
    bit   rst_prev = 1'b0, en_prev = 1'b1;
    win_t cur;

    always @(negedge clk) begin
        cyc++;
        chk("onehot0", $onehot0(bus_a.anodos), $sformatf("%b", bus_a.anodos), "at most one bit");
        chk("seg_needs_anode", !(bus_a.segmentos != 7'h00 && bus_a.anodos == 4'b0),
            $sformatf("seg=%h an=%b", bus_a.segmentos, bus_a.anodos), "no segments while dark");
        if (rst_prev) begin
            chk("reset_state", {bus_a.anodos, bus_a.segmentos, bus_a.digit_idx, bus_a.frame_done} == '0,
                $sformatf("an=%b seg=%h idx=%0d fd=%b", bus_a.anodos, bus_a.segmentos,
                          bus_a.digit_idx, bus_a.frame_done), "all zero");
        end else if (!en_prev) begin
            chk("disabled_state", {bus_a.anodos, bus_a.segmentos, bus_a.digit_idx, bus_a.frame_done} == '0,
                $sformatf("an=%b seg=%h idx=%0d fd=%b", bus_a.anodos, bus_a.segmentos,
                          bus_a.digit_idx, bus_a.frame_done), "all zero");
        end

        if (bus_a.frame_done) begin
            fr_a++;
            if (pv) chk("frame_period", (cyc - last_fr) == 40, $sformatf("%0d", cyc - last_fr), "40");
            last_fr = cyc;
            pv      = 1'b1;
        end

        if (bus_a.anodos != 4'b0) begin
            if (!in_win) begin
                in_win  = 1'b1;
                cur.an  = bus_a.anodos;
                cur.seg = bus_a.segmentos;
                cur.idx = bus_a.digit_idx;
                cur.len = 1;
                cur.gap = gap_a;
                cur.fr  = fr_a;
                fr_a    = 0;
                stable  = 1'b1;
            end else begin
                cur.len++;
                if (bus_a.anodos != cur.an || bus_a.segmentos != cur.seg || bus_a.digit_idx != cur.idx)
                    stable = 1'b0;
            end
        end else begin
            if (in_win) begin
                in_win = 1'b0;
                win_no++;
                if (q_a.size() == 0) begin
                    chk($sformatf("win_a%0d", win_no), 1'b0, wstr(cur), "no window");
                end else begin
                    win_t e;
                    e = q_a.pop_front();
                    chk($sformatf("win_a%0d", win_no),
                        e.an == cur.an && e.seg == cur.seg && e.idx == cur.idx &&
                        e.len == cur.len && e.gap == cur.gap && e.fr == cur.fr,
                        wstr(cur), wstr(e));
                    chk($sformatf("win_a%0d_stable", win_no), stable, "changed", "constant");
                end
                gap_a = 0;
            end
            gap_a++;
        end

        if (rst_a || !bus_a.enable) begin
            gap_a = 0;
            fr_a  = 0;
            pv    = 1'b0;
        end
        rst_prev = rst_a;
        en_prev  = bus_a.enable;
    end

    // ---------------- monitor B ----------------
    logic [2:0] an_b_prev = 3'b0;
    int         win_b_no  = 0;

    always @(negedge clk) begin
        if (!rst_b) begin
            chk("onehot0_b", $onehot0(bus_b.anodos), $sformatf("%b", bus_b.anodos), "at most one bit");
            if (bus_b.anodos != 3'b0 && an_b_prev == 3'b0) begin
                win_b_no++;
                if (q_b.size() == 0) begin
                    chk($sformatf("win_b%0d", win_b_no), 1'b0, $sformatf("an=%b", bus_b.anodos), "no window");
                end else begin
                    win_b_t e;
                    e = q_b.pop_front();
                    chk($sformatf("win_b%0d", win_b_no),
                        e.an == bus_b.anodos && e.seg == bus_b.segmentos && e.idx == bus_b.digit_idx,
                        $sformatf("an=%b seg=%h idx=%0d", bus_b.anodos, bus_b.segmentos, bus_b.digit_idx),
                        $sformatf("an=%b seg=%h idx=%0d", e.an, e.seg, e.idx));
                end
            end
        end
        an_b_prev = bus_b.anodos;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_a(input logic [3:0] an, input logic [6:0] seg, input logic [1:0] idx,
                         input int len, input int gap, input int fr);
        win_t w;
        w.an = an; w.seg = seg; w.idx = idx; w.len = len; w.gap = gap; w.fr = fr;
        q_a.push_back(w);
    endtask

    task automatic exp_b(input logic [2:0] an, input logic [6:0] seg, input logic [1:0] idx);
        win_b_t w;
        w.an = an; w.seg = seg; w.idx = idx;
        q_b.push_back(w);
    endtask

    task automatic wait_qa(input int n, input int budget, input string tag);
        int c = 0;
        while (q_a.size() > n && c < budget) begin
            tick(1);
            c++;
        end
        chk(tag, q_a.size() <= n, $sformatf("%0d pending", q_a.size()), $sformatf("<= %0d pending", n));
    endtask

    task automatic wait_qb(input int budget, input string tag);
        int c = 0;
        while (q_b.size() > 0 && c < budget) begin
            tick(1);
            c++;
        end
        chk(tag, q_b.size() == 0, $sformatf("%0d pending", q_b.size()), "0 pending");
    endtask

    task automatic wait_an_a(input logic [3:0] target, input int budget, input string tag);
        int c = 0;
        while (bus_a.anodos != target && c < budget) begin
            tick(1);
            c++;
        end
        chk(tag, bus_a.anodos == target, $sformatf("%b", bus_a.anodos), $sformatf("%b", target));
    endtask

    task automatic wr_a(input logic [1:0] addr, input logic [4:0] data);
        bus_a.wr_en   = 1'b1;
        bus_a.wr_addr = addr;
        bus_a.wr_data = data;
        tick(1);
        bus_a.wr_en   = 1'b0;
    endtask

    task automatic wr_b(input logic [1:0] addr, input logic [4:0] data);
        bus_b.wr_en   = 1'b1;
        bus_b.wr_addr = addr;
        bus_b.wr_data = data;
        tick(1);
        bus_b.wr_en   = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_a = 1'b1; bus_a.enable = 1'b0; bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
        rst_b = 1'b1; bus_b.enable = 1'b0; bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
        tick(3);

        // Two all-blank frames after reset.
        exp_a(4'b0001, 7'h00, 2'd0, 8, 3, 0);
        exp_a(4'b0010, 7'h00, 2'd1, 8, 2, 0);
        exp_a(4'b0100, 7'h00, 2'd2, 8, 2, 0);
        exp_a(4'b1000, 7'h00, 2'd3, 8, 2, 0);
        exp_a(4'b0001, 7'h00, 2'd0, 8, 2, 1);
        exp_a(4'b0010, 7'h00, 2'd1, 8, 2, 0);
        exp_a(4'b0100, 7'h00, 2'd2, 8, 2, 0);
        exp_a(4'b1000, 7'h00, 2'd3, 8, 2, 0);
        rst_a = 1'b0;
        bus_a.enable = 1'b1;

        // Load 0,1,2,F while frame 2 drives digit 3.
        wait_qa(1, 200, "reach_f2_d3");
        wait_an_a(4'b1000, 20, "an_f2_d3");
        wr_a(2'd0, 5'h00);
        wr_a(2'd1, 5'h01);
        wr_a(2'd2, 5'h02);
        wr_a(2'd3, 5'h0F);
        exp_a(4'b0001, 7'h3F, 2'd0, 8, 2, 1);
        exp_a(4'b0010, 7'h06, 2'd1, 8, 2, 0);
        exp_a(4'b0100, 7'h5B, 2'd2, 8, 2, 0);
        exp_a(4'b1000, 7'h71, 2'd3, 8, 2, 0);

        // Rewrite digit 1 mid-drive: current dwell keeps 06.
        wait_an_a(4'b0010, 40, "an_f3_d1");
        tick(2);
        wr_a(2'd1, 5'h08);
        // Blank digit 3 (hex 5 with flag) during its frame-3 drive.
        wait_an_a(4'b1000, 40, "an_f3_d3");
        wr_a(2'd3, 5'h15);
        exp_a(4'b0001, 7'h3F, 2'd0, 8, 2, 1);
        exp_a(4'b0010, 7'h7F, 2'd1, 8, 2, 0);
        exp_a(4'b0100, 7'h5B, 2'd2, 8, 2, 0);
        exp_a(4'b1000, 7'h00, 2'd3, 8, 2, 0);
        exp_a(4'b0001, 7'h3F, 2'd0, 8, 2, 1);
        exp_a(4'b0010, 7'h7F, 2'd1, 8, 2, 0);
        exp_a(4'b0100, 7'h5B, 2'd2, 4, 2, 0);

        // Disable after 4 drive cycles of digit 2 in frame 5.
        wait_qa(1, 200, "reach_f5_d2");
        wait_an_a(4'b0100, 20, "an_f5_d2");
        tick(3);
        bus_a.enable = 1'b0;
        tick(2);
        wr_a(2'd2, 5'h05);
        tick(2);
        wait_qa(0, 10, "drain_disable");

        // Re-enable: restart at digit 0; reset hits during digit 2 with a write to digit 0.
        exp_a(4'b0001, 7'h3F, 2'd0, 8, 3, 0);
        exp_a(4'b0010, 7'h7F, 2'd1, 8, 2, 0);
        exp_a(4'b0100, 7'h6D, 2'd2, 3, 2, 0);
        bus_a.enable = 1'b1;
        wait_qa(1, 100, "reach_f6_d2");
        wait_an_a(4'b0100, 20, "an_f6_d2");
        tick(2);
        rst_a = 1'b1;
        bus_a.wr_en = 1'b1; bus_a.wr_addr = 2'd0; bus_a.wr_data = 5'h07;
        tick(1);
        bus_a.wr_en = 1'b0;
        tick(2);

        exp_a(4'b0001, 7'h00, 2'd0, 8, 3, 0);
        exp_a(4'b0010, 7'h00, 2'd1, 8, 2, 0);
        exp_a(4'b0100, 7'h00, 2'd2, 8, 2, 0);
        exp_a(4'b1000, 7'h00, 2'd3, 8, 2, 0);
        rst_a = 1'b0;
        wait_qa(0, 100, "drain_after_reset");
        bus_a.enable = 1'b0;

        // Three-digit instance: address 3 is out of range and must be dropped.
        rst_b = 1'b0;
        tick(1);
        wr_b(2'd0, 5'h01);
        wr_b(2'd1, 5'h02);
        wr_b(2'd2, 5'h03);
        wr_b(2'd3, 5'h08);
        exp_b(3'b001, 7'h06, 2'd0);
        exp_b(3'b010, 7'h5B, 2'd1);
        exp_b(3'b100, 7'h4F, 2'd2);
        exp_b(3'b001, 7'h06, 2'd0);
        exp_b(3'b010, 7'h5B, 2'd1);
        bus_b.enable = 1'b1;
        tick(5);
        wr_b(2'd3, 5'h00);
        wait_qb(100, "drain_b");
        tick(3);

        chk("q_a_empty", q_a.size() == 0, $sformatf("%0d", q_a.size()), "0");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
